acq_sequencer: RTL and testbench
================================

Name: acq_sequencer

Overview:
- Sequences one Raman acquisition run: per sync trigger, sweeps POINTS ADC samples into an external dual-port accumulation RAM using read-modify-write.
- After MEASURES sweeps, streams the accumulated spectrum out over a valid/ready dump port.
- Repeats for SAVES spectra, then returns to idle.
- Sits between the trigger/ADC front end and the accumulation RAM plus host-transfer logic.

Parameters:
- POINTS, 1024, samples per sweep (RAM depth); AW = $clog2(POINTS).
- MEASURES, 100000, sweeps accumulated per spectrum; MW = $clog2(MEASURES).
- SAVES, 10, spectra per run; SW = $clog2(SAVES).
- RD_LAT, 2, RAM read latency in clocks (1..4).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  single-cycle pulse; begins a run from IDLE and is ignored elsewhere.
- abort  in  1  synchronous; forces IDLE.
- sync  in  1  sweep trigger, already synchronous to clk; the rising edge is used.
- ram_rd_en  out  1  accumulation read strobe.
- ram_rd_addr  out  AW  read address; during DUMP this carries the dump address.
- ram_wr_en  out  1  accumulation write strobe.
- ram_wr_addr  out  AW  write address.
- acc_clear  out  1  datapath adds to zero instead of RAM data; qualifies ram_wr_en.
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  downstream accepts the beat.
- dump_last  out  1  last beat of a spectrum.
- cnt_point  out  AW  current sweep point.
- cnt_measure  out  MW  completed sweeps in the current spectrum.
- cnt_save  out  SW  completed spectra.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at end of run.
- overrun  out  1  sticky: sync edge seen while not in WAIT_SYNC; cleared by start.

Behaviour:
- Reset: state IDLE; every output 0; internal sync_d = 0.
- sync_rise = sync & ~sync_d.
- States: IDLE, WAIT_SYNC, SWEEP, FLUSH, DUMP.
- IDLE: on start, clear counters and overrun, go to WAIT_SYNC.
- WAIT_SYNC: on sync_rise, go to SWEEP with cnt_point = 0.
- SWEEP:
  - Each cycle: ram_rd_en = 1, ram_rd_addr = cnt_point.
  - cnt_point increments each cycle; after POINTS-1, go to FLUSH.
  - Exactly POINTS reads per sweep.
- Write pipeline:
  - Read address and valid are delayed L = RD_LAT+1 cycles (the +1 is the datapath adder register).
  - They drive ram_wr_addr and ram_wr_en.
  - acc_clear is delayed the same way; it is 1 for every write while cnt_measure == 0.
- FLUSH:
  - Lasts exactly L cycles so the last write retires; no reads in FLUSH.
  - Then cnt_measure increments.
  - If the new value equals MEASURES, reset cnt_measure to 0 and go to DUMP. Otherwise go to WAIT_SYNC.
- Read/write collision:
  - Same-address read/write never occurs within a sweep (a sweep touches each address once).
  - The next sweep's first read of addr 0 cannot start before FLUSH ends, so there is no RAW hazard.
- DUMP:
  - dump_valid = 1; ram_rd_addr = dump address, starting at 0; ram_rd_en = 1.
  - The address advances only on dump_valid & dump_ready.
  - When stalled, the address and dump_valid hold.
  - dump_last = 1 when the address = POINTS-1.
  - On the last accepted beat, cnt_save increments.
  - If the new value = SAVES: cnt_save returns to 0, pulse done, go to IDLE. Otherwise go to WAIT_SYNC.
  - The dump address is an index only; data alignment for RD_LAT is the downstream consumer's job.
- overrun: set by sync_rise in SWEEP, FLUSH or DUMP; that edge is otherwise ignored (no queuing).
- abort:
  - From any state, next cycle goes to IDLE.
  - ram_rd_en, ram_wr_en and dump_valid are forced 0 immediately (registered next edge).
  - In-flight pipeline writes are discarded.
  - Counters are cleared; done is not pulsed.
- rst mid-operation: same effect as abort but asynchronous.
- Simultaneous start & abort in IDLE: abort wins, stay in IDLE.
- All counter arithmetic is unsigned; no counter exceeds its terminal value.

Decomposition:
- Package acq_pkg: state enum (IDLE, WAIT_SYNC, SWEEP, FLUSH, DUMP) and default parameter constants.
- One sub-module: acq_wr_pipe, a parameterised L-stage shift register carrying {valid, clear, addr}, with a flush-on-abort input.

Test Plan (POINTS=8, MEASURES=3, SAVES=2, RD_LAT=2, L=3):
- Basic run: start, then 6 sync pulses spaced 20 clk, dump_ready=1.
  - Expect 8 reads per sweep on addrs 0..7.
  - Each write addr lags its read by 3 clk.
  - acc_clear=1 only on sweeps 1 and 4.
  - Two dumps of 8 beats with dump_last on beat 7; done at end; cnt_save=0.
- Backpressure: dump_ready toggling 1/0.
  - Each address is presented until accepted; exactly 8 handshakes; no address skipped or repeated.
- Overrun: sync rise at SWEEP cycle 4.
  - overrun=1; sweep completes normally with 8 reads; next sync accepted; a new start clears overrun.
- Abort mid-SWEEP at point 5: following cycle rd/wr strobes = 0, state IDLE, counters 0, no done.
- Async rst asserted mid-DUMP: all outputs 0 without waiting for a clock edge; after release, a start gives a clean run.
- start+abort same cycle in IDLE: busy stays 0.

Source files
------------

// File: rtl/acq_pkg.sv
// Shared state encoding and default sizing for the Raman acquisition sequencer.
package acq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_SYNC = 3'd1,
    SWEEP     = 3'd2,
    FLUSH     = 3'd3,
    DUMP      = 3'd4
  } acq_state_e;

  localparam int DEF_POINTS   = 1024;
  localparam int DEF_MEASURES = 100000;
  localparam int DEF_SAVES    = 10;
  localparam int DEF_RD_LAT   = 2;

  // Width of a counter that runs 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acq_wr_pipe.sv
// L-stage delay line carrying {valid, clear, addr} from the RAM read side to the
// accumulation write side; a synchronous flush drops everything in flight.
module acq_wr_pipe #(
  parameter int L  = 3,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic          in_clear,
  input  logic [AW-1:0] in_addr,
  output logic          out_valid,
  output logic          out_clear,
  output logic [AW-1:0] out_addr
);

  localparam int DW = AW + 2;

  logic [DW-1:0] stage [L];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < L; i++) stage[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < L; i++) stage[i] <= '0;
    end else begin
      // clear only travels with a valid entry so idle slots never assert acc_clear
      stage[0] <= {in_valid, in_valid & in_clear, in_addr};
      for (int i = 1; i < L; i++) stage[i] <= stage[i-1];
    end
  end

  assign {out_valid, out_clear, out_addr} = stage[L-1];

endmodule

// File: rtl/acq_sequencer.sv
// Raman acquisition run sequencer: per sync edge sweeps POINTS samples through a
// read-modify-write accumulation RAM, dumps each spectrum, repeats SAVES times.
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int  POINTS   = DEF_POINTS,
  parameter int  MEASURES = DEF_MEASURES,
  parameter int  SAVES    = DEF_SAVES,
  parameter int  RD_LAT   = DEF_RD_LAT,
  localparam int AW       = cnt_width(POINTS),
  localparam int MW       = cnt_width(MEASURES),
  localparam int SW       = cnt_width(SAVES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          sync,
  output logic          ram_rd_en,
  output logic [AW-1:0] ram_rd_addr,
  output logic          ram_wr_en,
  output logic [AW-1:0] ram_wr_addr,
  output logic          acc_clear,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic          dump_last,
  output logic [AW-1:0] cnt_point,
  output logic [MW-1:0] cnt_measure,
  output logic [SW-1:0] cnt_save,
  output logic          busy,
  output logic          done,
  output logic          overrun,
  output acq_state_e    dbg_state
);

  // Read latency plus the datapath adder register.
  localparam int L  = RD_LAT + 1;
  localparam int FW = cnt_width(L);

  localparam logic [AW-1:0] PT_LAST    = AW'(POINTS - 1);
  localparam logic [MW-1:0] MEAS_LAST  = MW'(MEASURES - 1);
  localparam logic [SW-1:0] SAVE_LAST  = SW'(SAVES - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(L - 1);

  acq_state_e    state, state_nx;
  logic [AW-1:0] point_q, point_nx;
  logic [AW-1:0] dump_addr_q, dump_addr_nx;
  logic [MW-1:0] meas_q, meas_nx;
  logic [SW-1:0] save_q, save_nx;
  logic [FW-1:0] flush_q, flush_nx;
  logic          sync_d, sync_rise;
  logic          overrun_q, overrun_nx;
  logic          done_q, done_nx;

  assign sync_rise = sync & ~sync_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      point_q     <= '0;
      dump_addr_q <= '0;
      meas_q      <= '0;
      save_q      <= '0;
      flush_q     <= '0;
      sync_d      <= 1'b0;
      overrun_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_nx;
      point_q     <= point_nx;
      dump_addr_q <= dump_addr_nx;
      meas_q      <= meas_nx;
      save_q      <= save_nx;
      flush_q     <= flush_nx;
      sync_d      <= sync;
      overrun_q   <= overrun_nx;
      done_q      <= done_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    point_nx     = point_q;
    dump_addr_nx = dump_addr_q;
    meas_nx      = meas_q;
    save_nx      = save_q;
    flush_nx     = flush_q;
    overrun_nx   = overrun_q;
    done_nx      = 1'b0;

    if (abort) begin
      // abort beats start, drops the run without a done pulse; overrun is kept
      state_nx     = IDLE;
      point_nx     = '0;
      dump_addr_nx = '0;
      meas_nx      = '0;
      save_nx      = '0;
      flush_nx     = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nx     = WAIT_SYNC;
            point_nx     = '0;
            dump_addr_nx = '0;
            meas_nx      = '0;
            save_nx      = '0;
            flush_nx     = '0;
            overrun_nx   = 1'b0;
          end
        end

        WAIT_SYNC: begin
          if (sync_rise) begin
            state_nx = SWEEP;
            point_nx = '0;
          end
        end

        SWEEP: begin
          if (sync_rise) overrun_nx = 1'b1;
          if (point_q == PT_LAST) begin
            point_nx = '0;
            flush_nx = '0;
            state_nx = FLUSH;
          end else begin
            point_nx = point_q + AW'(1);
          end
        end

        // Hold off the next sweep until the last write has left the pipeline.
        FLUSH: begin
          if (sync_rise) overrun_nx = 1'b1;
          if (flush_q == FLUSH_LAST) begin
            flush_nx = '0;
            if (meas_q == MEAS_LAST) begin
              meas_nx      = '0;
              dump_addr_nx = '0;
              state_nx     = DUMP;
            end else begin
              meas_nx  = meas_q + MW'(1);
              state_nx = WAIT_SYNC;
            end
          end else begin
            flush_nx = flush_q + FW'(1);
          end
        end

        // A beat transfers on dump_valid & dump_ready in the same cycle; while
        // dump_ready is low the address and dump_valid are held unchanged.
        DUMP: begin
          if (sync_rise) overrun_nx = 1'b1;
          if (dump_ready) begin
            if (dump_addr_q == PT_LAST) begin
              dump_addr_nx = '0;
              if (save_q == SAVE_LAST) begin
                save_nx  = '0;
                done_nx  = 1'b1;
                state_nx = IDLE;
              end else begin
                save_nx  = save_q + SW'(1);
                state_nx = WAIT_SYNC;
              end
            end else begin
              dump_addr_nx = dump_addr_q + AW'(1);
            end
          end
        end

        default: state_nx = IDLE;
      endcase
    end
  end

  acq_wr_pipe #(
    .L  (L),
    .AW (AW)
  ) u_wr_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .in_valid  (state == SWEEP),
    .in_clear  (meas_q == '0),
    .in_addr   (point_q),
    .out_valid (ram_wr_en),
    .out_clear (acc_clear),
    .out_addr  (ram_wr_addr)
  );

  assign ram_rd_en   = (state == SWEEP) || (state == DUMP);
  assign ram_rd_addr = (state == DUMP)  ? dump_addr_q :
                       (state == SWEEP) ? point_q     : '0;
  assign dump_valid  = (state == DUMP);
  assign dump_last   = (state == DUMP) && (dump_addr_q == PT_LAST);
  assign cnt_point   = point_q;
  assign cnt_measure = meas_q;
  assign cnt_save    = save_q;
  assign busy        = (state != IDLE);
  assign done        = done_q;
  assign overrun     = overrun_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_acq_sequencer.sv
// Randomized scoreboard bench for acq_sequencer: a run-level model predicts the
// read, write, dump and done streams; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_acq_sequencer;
  import acq_pkg::*;

  localparam int POINTS   = 8;
  localparam int MEASURES = 3;
  localparam int SAVES    = 2;
  localparam int RD_LAT   = 2;
  localparam int L        = RD_LAT + 1;
  localparam int AW       = 3;
  localparam int MW       = 2;
  localparam int SW       = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          sync = 1'b0;
  logic          dump_ready = 1'b0;
  logic          ram_rd_en, ram_wr_en, acc_clear, dump_valid, dump_last;
  logic          busy, done, overrun;
  logic [AW-1:0] ram_rd_addr, ram_wr_addr, cnt_point;
  logic [MW-1:0] cnt_measure;
  logic [SW-1:0] cnt_save;
  acq_state_e    dbg_state;

  acq_sequencer #(
    .POINTS   (POINTS),
    .MEASURES (MEASURES),
    .SAVES    (SAVES),
    .RD_LAT   (RD_LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .sync        (sync),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .acc_clear   (acc_clear),
    .dump_valid  (dump_valid),
    .dump_ready  (dump_ready),
    .dump_last   (dump_last),
    .cnt_point   (cnt_point),
    .cnt_measure (cnt_measure),
    .cnt_save    (cnt_save),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [AW-1:0] exp_rd_q[$];
  logic [AW:0]   exp_wr_q[$];    // {clear, addr}
  logic [AW:0]   exp_dump_q[$];  // {last, addr}
  logic          exp_done_q[$];
  int            rd_cyc_q[$];
  int            ready_mode = 0;
  int            m_meas = 0;
  int            m_save = 0;
  bit            m_overrun = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got %0h expected no event at %0t", name, act, $time);
  endtask

  // ---------------- reference model ----------------
  // One accepted sync = one full sweep; every MEASURES sweeps yields a dump,
  // every SAVES dumps ends the run with a done pulse.
  task automatic model_sweep();
    for (int a = 0; a < POINTS; a++) begin
      exp_rd_q.push_back(AW'(a));
      exp_wr_q.push_back({(m_meas == 0), AW'(a)});
    end
    m_meas++;
    if (m_meas == MEASURES) begin
      m_meas = 0;
      for (int a = 0; a < POINTS; a++) exp_dump_q.push_back({(a == POINTS - 1), AW'(a)});
      m_save++;
      if (m_save == SAVES) begin
        m_save = 0;
        exp_done_q.push_back(1'b1);
      end
    end
  endtask

  task automatic reset_model();
    exp_rd_q.delete();
    exp_wr_q.delete();
    exp_dump_q.delete();
    exp_done_q.delete();
    rd_cyc_q.delete();
    m_meas = 0;
    m_save = 0;
  endtask

  function automatic int pending();
    return exp_rd_q.size() + exp_wr_q.size() + exp_dump_q.size() + exp_done_q.size();
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    m_meas = 0;
    m_save = 0;
    m_overrun = 1'b0;
    tick(1);
    start = 1'b0;
  endtask

  task automatic sync_pulse(input int width, input int gap);
    model_sweep();
    sync = 1'b1;
    tick(width);
    sync = 1'b0;
    tick(gap - width);
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while (pending() != 0 && t < budget) begin
      tick(1);
      t++;
    end
    check("drain_complete", 32'(pending() == 0), 32'd1);
    tick(2);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_cnt_point"},   32'(cnt_point),   32'd0);
    check({tag, "_cnt_measure"}, 32'(cnt_measure), 32'(m_meas));
    check({tag, "_cnt_save"},    32'(cnt_save),    32'(m_save));
    check({tag, "_overrun"},     32'(overrun),     32'(m_overrun));
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, acc_clear, dump_valid,
                dump_last, cnt_point, cnt_measure, cnt_save, busy, done, overrun});
  endfunction

  // dump_ready pattern: 0 always ready, 1 toggling, 2 random (never two idle
  // cycles in a row), 3 held low
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       dump_ready = 1'b1;
        1:       dump_ready = ~dump_ready;
        2:       dump_ready = dump_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        default: dump_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin
    int            mon_cyc = 0;
    bit            prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("dump_hold_valid", 32'(dump_valid), 32'd1);
          check("dump_hold_addr", 32'(ram_rd_addr), 32'(prev_addr));
        end
        prev_stall = dump_valid && !dump_ready;
        prev_addr  = ram_rd_addr;

        if (ram_rd_en && !dump_valid) begin
          if (exp_rd_q.size() == 0) unexpected("rd_extra", 32'(ram_rd_addr));
          else check("rd_addr", 32'(ram_rd_addr), 32'(exp_rd_q.pop_front()));
          rd_cyc_q.push_back(mon_cyc);
        end

        if (ram_wr_en) begin
          if (exp_wr_q.size() == 0) unexpected("wr_extra", 32'({acc_clear, ram_wr_addr}));
          else check("wr_clear_addr", 32'({acc_clear, ram_wr_addr}), 32'(exp_wr_q.pop_front()));
          if (rd_cyc_q.size() == 0) unexpected("wr_without_read", 32'(ram_wr_addr));
          else check("wr_lag", 32'(mon_cyc - rd_cyc_q.pop_front()), 32'(L));
        end

        if (dump_valid && dump_ready) begin
          if (exp_dump_q.size() == 0) unexpected("dump_extra", 32'({dump_last, ram_rd_addr}));
          else check("dump_last_addr", 32'({dump_last, ram_rd_addr}), 32'(exp_dump_q.pop_front()));
        end

        if (done) begin
          if (exp_done_q.size() == 0) unexpected("done_extra", 32'd1);
          else begin
            void'(exp_done_q.pop_front());
            check("done_in_idle", 32'(busy), 32'd0);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset state
    tick(3);
    check("rst_outputs", all_outputs(), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    #2 rst = 1'b0;
    tick(2);
    check("idle_busy", 32'(busy), 32'd0);

    // basic run, sync spaced 20 clocks, always ready
    ready_mode = 0;
    do_start();
    check("start_busy", 32'(busy), 32'd1);
    check("start_state", 32'(dbg_state), 32'(WAIT_SYNC));
    repeat (6) sync_pulse(1, 20);
    drain(100);
    check_counters("basic");
    check("basic_busy", 32'(busy), 32'd0);

    // backpressure: dump_ready toggling
    ready_mode = 1;
    do_start();
    repeat (6) sync_pulse(1, 40);
    drain(200);
    check_counters("bp");

    // randomized runs: pulse width, spacing and ready pattern
    ready_mode = 2;
    repeat (2) begin
      do_start();
      repeat (4) sync_pulse(int'($urandom_range(1, 3)), int'($urandom_range(32, 45)));
      drain(200);
      check_counters("rand_mid");
      repeat (2) sync_pulse(int'($urandom_range(1, 3)), int'($urandom_range(32, 45)));
      drain(200);
      check_counters("rand_end");
    end

    // overrun: extra sync edge at sweep point 4
    ready_mode = 0;
    do_start();
    model_sweep();
    sync = 1'b1;
    tick(1);
    sync = 1'b0;
    tick(4);
    sync = 1'b1;
    m_overrun = 1'b1;
    tick(1);
    sync = 1'b0;
    check("overrun_set", 32'(overrun), 32'd1);
    tick(14);
    repeat (5) sync_pulse(1, 20);
    drain(100);
    check_counters("ovr");
    do_start();
    check("overrun_cleared_by_start", 32'(overrun), 32'(m_overrun));

    // abort at sweep point 5: reads 0..5 issued, writes 0..2 already retired
    for (int a = 0; a <= 5; a++) exp_rd_q.push_back(AW'(a));
    for (int a = 0; a <= 5 - L; a++) exp_wr_q.push_back({1'b1, AW'(a)});
    sync = 1'b1;
    tick(1);
    sync = 1'b0;
    tick(5);
    check("abort_at_point", 32'(cnt_point), 32'd5);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_rd_en", 32'(ram_rd_en), 32'd0);
    check("abort_wr_en", 32'(ram_wr_en), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    check("abort_counters", 32'({cnt_point, cnt_measure, cnt_save}), 32'd0);
    tick(6);
    check("abort_streams_done", 32'(pending()), 32'd0);
    reset_model();

    // async reset in the middle of a stalled dump
    ready_mode = 3;
    do_start();
    repeat (3) sync_pulse(1, 20);
    begin
      int t = 0;
      while (!dump_valid && t < 40) begin
        tick(1);
        t++;
      end
    end
    check("reached_dump", 32'(dump_valid), 32'd1);
    tick(3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outputs", all_outputs(), 32'd0);
    check("async_rst_state", 32'(dbg_state), 32'(IDLE));
    reset_model();
    m_overrun = 1'b0;
    tick(2);
    #3 rst = 1'b0;
    tick(2);
    check("post_rst_outputs", all_outputs(), 32'd0);
    ready_mode = 0;
    do_start();
    repeat (6) sync_pulse(1, 20);
    drain(100);
    check_counters("post_rst");

    // start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    tick(3);
    check("start_abort_state", 32'(dbg_state), 32'(IDLE));
    check("final_streams_empty", 32'(pending()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
